// File: rtl/fifo_rd_stream.sv
// Read-side adapter that turns a FIFO head/pop interface into a valid/ready stream.
// A two-entry skid buffer lets the FIFO be popped without waiting on m_ready.
module fifo_rd_stream #(
   parameter int DATASIZE = 8
) (
   input  logic                rclk,
   input  logic                rrst,
   input  logic                rempty,
   input  logic [DATASIZE-1:0] rdata,
   output logic                rinc,
   input  logic                flush,
   output logic                m_valid,
   output logic [DATASIZE-1:0] m_data,
   input  logic                m_ready,
   output logic [1:0]          occupancy
);

   logic [1:0]          count_q, count_d;
   logic                valid_q, valid_d;
   logic [DATASIZE-1:0] head_q, head_d;
   logic [DATASIZE-1:0] tail_q, tail_d;
   logic                push;
   logic                pop;

   // Pop the FIFO whenever there is room, independent of downstream ready.
   assign rinc = !rrst && !flush && !rempty && (count_q != 2'd2);
   assign push = rinc;
   assign pop  = valid_q && m_ready;

   always_comb begin
      count_d = count_q;
      head_d  = head_q;
      tail_d  = tail_q;
      if (flush) begin
         count_d = 2'd0;
      end else begin
         unique case ({push, pop})
            2'b10: begin
               if (count_q == 2'd0) begin
                  head_d  = rdata;
                  count_d = 2'd1;
               end else begin
                  tail_d  = rdata;
                  count_d = 2'd2;
               end
            end
            2'b01: begin
               if (count_q == 2'd2) begin
                  head_d  = tail_q;
                  count_d = 2'd1;
               end else begin
                  count_d = 2'd0;
               end
            end
            // Simultaneous push and pop only occurs with one word held.
            2'b11: begin
               head_d = rdata;
            end
            default: begin
               count_d = count_q;
            end
         endcase
      end
      valid_d = (count_d != 2'd0);
   end

   always_ff @(posedge rclk) begin
      if (rrst) begin
         count_q <= 2'd0;
         valid_q <= 1'b0;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         count_q <= count_d;
         valid_q <= valid_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

   assign m_valid   = valid_q;
   assign m_data    = head_q;
   assign occupancy = count_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream: a queue-modelled source FIFO feeds the DUT,
// words taken from it are expected downstream in order unless flushed or reset away.
module tb_fifo_rd_stream;

   localparam int DATASIZE = 8;

   logic                rclk;
   logic                rrst;
   logic                rempty;
   logic [DATASIZE-1:0] rdata;
   logic                rinc;
   logic                flush;
   logic                m_valid;
   logic [DATASIZE-1:0] m_data;
   logic                m_ready;
   logic [1:0]          occupancy;

   logic [DATASIZE-1:0] srcQ[$];
   logic [DATASIZE-1:0] expQ[$];
   logic                holdEmpty;
   logic                cleanReset;
   int                  compareCount;
   int                  failCount;

   fifo_rd_stream #(.DATASIZE(DATASIZE)) dut (
      .rclk      (rclk),
      .rrst      (rrst),
      .rempty    (rempty),
      .rdata     (rdata),
      .rinc      (rinc),
      .flush     (flush),
      .m_valid   (m_valid),
      .m_data    (m_data),
      .m_ready   (m_ready),
      .occupancy (occupancy)
   );

   initial rclk = 1'b0;
   always #5 rclk = ~rclk;

   task automatic checkOutput(input string name, input logic [DATASIZE-1:0] actual,
                              input logic [DATASIZE-1:0] required);
      compareCount++;
      if (actual !== required) begin
         failCount++;
         $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, required);
      end
   endtask

   task automatic applyStimulus(input logic rst, input logic fl, input logic rdy, input logic hold);
      @(negedge rclk);
      rrst      = rst;
      flush     = fl;
      m_ready   = rdy;
      holdEmpty = hold;
   endtask

   task automatic preload(input logic [DATASIZE-1:0] first, input int n);
      for (int i = 0; i < n; i++) srcQ.push_back(first + DATASIZE'(i));
   endtask

   task automatic waitDrain(input int maxCycles);
      int cycles;
      cycles = 0;
      while ((srcQ.size() != 0 || expQ.size() != 0) && cycles < maxCycles) begin
         @(negedge rclk);
         cycles++;
      end
      compareCount++;
      if (srcQ.size() != 0 || expQ.size() != 0) begin
         failCount++;
         $display("[TB] FAIL drain_timeout at %0t: src=%0d pending=%0d, expected 0/0",
                  $time, srcQ.size(), expQ.size());
      end
   endtask

   // Source FIFO presentation and scoreboard: sample just before each edge, apply just after.
   initial begin
      logic expRinc, sRst, sFlush, sPop, sPush, sRinc;
      logic [DATASIZE-1:0] sWord;
      int pending;
      forever begin
         @(negedge rclk);
         #1;
         rempty = holdEmpty || (srcQ.size() == 0);
         rdata  = (srcQ.size() != 0) ? srcQ[0] : '0;
         #3;
         pending = expQ.size();
         expRinc = !rrst && !flush && !rempty && (pending < 2);
         checkOutput("rinc", DATASIZE'(rinc), DATASIZE'(expRinc));
         checkOutput("m_valid", DATASIZE'(m_valid), DATASIZE'(pending != 0));
         checkOutput("occupancy", DATASIZE'(occupancy), DATASIZE'(pending));
         if (m_valid === 1'b1) begin
            if (pending != 0) checkOutput("m_data", m_data, expQ[0]);
            else checkOutput("m_data_unexpected", DATASIZE'(m_valid), '0);
         end
         if (cleanReset) checkOutput("m_data_reset", m_data, '0);
         sRst   = rrst;
         sFlush = flush;
         sPop   = (pending != 0) && m_ready;
         sPush  = expRinc;
         sRinc  = (rinc === 1'b1);
         sWord  = rdata;
         @(posedge rclk);
         #1;
         if (sRinc && srcQ.size() != 0) void'(srcQ.pop_front());
         if (sRst) begin
            expQ.delete();
            cleanReset = 1'b1;
         end else if (sFlush) begin
            expQ.delete();
         end else begin
            if (sPop) void'(expQ.pop_front());
            if (sPush) begin
               expQ.push_back(sWord);
               cleanReset = 1'b0;
            end
         end
         rempty = holdEmpty || (srcQ.size() == 0);
         rdata  = (srcQ.size() != 0) ? srcQ[0] : '0;
      end
   end

   initial begin
      compareCount = 0;
      failCount    = 0;
      cleanReset   = 1'b0;
      rrst         = 1'b1;
      flush        = 1'b0;
      m_ready      = 1'b0;
      holdEmpty    = 1'b0;
      rempty       = 1'b1;
      rdata        = '0;

      // Reset with data waiting: no pops, outputs cleared.
      preload(8'h11, 5);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);

      // Streaming at one word per cycle.
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      waitDrain(30);

      // Backpressure fills both entries, then drains in order.
      preload(8'hA0, 4);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      repeat (5) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      waitDrain(30);

      // Empty boundary with single words.
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      srcQ.push_back(8'h01);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      waitDrain(10);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      srcQ.push_back(8'h02);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      waitDrain(10);

      // Flush with two words buffered; the following word still arrives.
      preload(8'h5A, 3);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      waitDrain(20);

      // Reset mid-operation at full occupancy with ready high.
      preload(8'hC0, 4);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      waitDrain(20);

      // Randomized traffic, including occasional flush and reset.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if ($urandom_range(1) == 1 && srcQ.size() < 8) srcQ.push_back(DATASIZE'($urandom));
         applyStimulus($urandom_range(99) == 0, $urandom_range(39) == 0,
                       $urandom_range(2) != 0, $urandom_range(3) == 0);
      end
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      waitDrain(40);
      repeat (2) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule
